serial_word_deserializer: RTL and testbench
===========================================

Name: serial_word_deserializer

Overview:
- Input stage of the fir_filter top level. Sits between the bit-serial sample source and the FIR core.
- Runs a one-cycle ready handshake with the source, then shifts in DATA_WIDTH bits, one bit per clock, LSB first.
- Presents the assembled word to the FIR core over a valid/ready interface.
- Holds the word until the core accepts it, and aborts incomplete frames.

Parameters:
- DATA_WIDTH, 24, sample word width in bits; must be >= 2.
- CNT_WIDTH, $clog2(DATA_WIDTH), width of the bit counter (derived; not overridden).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_din  in  1  serial data bit, LSB first.
- i_din_valid  in  1  source requests a frame; held high for the whole frame.
- o_ready  out  1  one-cycle grant to the source; source starts bits on the following cycle.
- o_word  out  DATA_WIDTH  assembled sample to FIR core.
- o_word_valid  out  1  o_word holds an unconsumed sample.
- i_word_ready  in  1  FIR core accepts o_word on an edge where o_word_valid=1.
- o_busy  out  1  high in ARM and SHIFT states.
- o_frame_err  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE; bit counter and shift register are cleared.
  - o_ready=0, o_word=0, o_word_valid=0, o_busy=0, o_frame_err=0.
  - A partial frame in flight is discarded with no error pulse.
- FSM states: IDLE, ARM, SHIFT, WAIT_LOW.
- IDLE -> ARM when i_din_valid=1 and the buffer is free or draining (o_word_valid=0 or i_word_ready=1). Otherwise stay in IDLE (backpressure).
- ARM: lasts exactly 1 cycle; o_ready=1 only in this state. Then -> SHIFT with counter=0.
- SHIFT: on each edge, sample i_din into bit[counter] and increment counter.
  - The first sample is taken on the edge after the ARM->SHIFT edge, i.e. 2 edges after o_ready rises.
  - On the edge that samples bit DATA_WIDTH-1: load o_word with the full word, set o_word_valid=1, go to WAIT_LOW.
- SHIFT abort: if i_din_valid=0 is sampled on any SHIFT edge before the final bit, discard the partial word, pulse o_frame_err for 1 cycle, and go to IDLE. o_word and o_word_valid are untouched.
- WAIT_LOW: stay until i_din_valid=0 is sampled, then go to IDLE. This forces one valid-low gap between frames so a held-high valid cannot re-arm.
- Latency: o_word_valid rises on the edge sampling the last bit, i.e. DATA_WIDTH+1 edges after the o_ready-rise edge.
- Output handshake:
  - o_word is stable while o_word_valid=1.
  - o_word_valid clears on an edge with i_word_ready=1, unless a new word loads on the same edge; in that case valid stays 1 and o_word takes the new value.
  - i_word_ready while o_word_valid=0 is ignored.
- Overwrite: by construction a frame cannot complete over an unconsumed word, because arming requires the buffer to be free or draining. The bench asserts this never happens.
- Counter: saturates at DATA_WIDTH-1 and never wraps mid-frame; it resets to 0 on entry to SHIFT.

Decomposition:
- fir_filter_pkg holds:
  - state enum typedef (deser_state_t: IDLE, ARM, SHIFT, WAIT_LOW);
  - the default DATA_WIDTH constant (24), shared with the FIR core and serializer;
  - a sample_t typedef of logic [DATA_WIDTH-1:0].
- Single module; no sub-module. The output holding register is simple enough to stay inline.

Test Plan:
- Single frame: reset, raise i_din_valid, serialize 0x5A3C81 LSB first starting the cycle after o_ready. Expect o_word=0x5A3C81, o_word_valid=1 exactly 25 edges after o_ready rose, o_frame_err=0.
- Extremes back-to-back: frames 0x7FFFFF then 0x800000 with a 1-cycle valid-low gap and i_word_ready=1. Expect both words in order, no errors, o_ready pulsing once per frame.
- Backpressure: i_word_ready=0, complete frame 0x000001, then request a second frame. Expect o_ready held 0 and o_word stable at 0x000001. Raise i_word_ready for 1 cycle: expect o_ready 1 cycle later and second word 0xABCDEF delivered.
- Abort: drop i_din_valid after 10 bits. Expect 1-cycle o_frame_err, o_word_valid unchanged, FSM in IDLE. The next full frame 0x123456 is received correctly.
- Reset mid-frame: deassert i_rst_n asynchronously after bit 12. Expect all outputs 0 immediately, no o_frame_err. After release, frame 0xFEDCBA is received correctly.
- Held valid: keep i_din_valid high for 40 cycles after the last bit. Expect no re-arm (o_ready=0) until valid falls and rises again.

Source files
------------

// File: rtl/fir_filter_pkg.sv
// Shared types and constants for the fir_filter datapath: sample width,
// sample type and the serial deserializer state encoding.
package fir_filter_pkg;

    localparam int DEFAULT_DATA_WIDTH = 24;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM      = 2'd1,
        SHIFT    = 2'd2,
        WAIT_LOW = 2'd3
    } deser_state_t;

    // A new frame may only be granted when the output buffer is empty or
    // being emptied on the same edge, so a completed frame never overwrites.
    function automatic logic buffer_can_accept(input logic word_valid,
                                               input logic word_ready);
        return (!word_valid) || word_ready;
    endfunction

endpackage

// File: rtl/serial_word_deserializer_if.sv
// Handshake bundle between the bit-serial source, the deserializer and the
// FIR core. The master side is the source/core environment.
interface serial_word_deserializer_if
    import fir_filter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    logic                  i_din;
    logic                  i_din_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] o_word;
    logic                  o_word_valid;
    logic                  i_word_ready;
    logic                  o_busy;
    logic                  o_frame_err;

    modport master (
        output i_din,
        output i_din_valid,
        output i_word_ready,
        input  o_ready,
        input  o_word,
        input  o_word_valid,
        input  o_busy,
        input  o_frame_err
    );

    modport slave (
        input  i_din,
        input  i_din_valid,
        input  i_word_ready,
        output o_ready,
        output o_word,
        output o_word_valid,
        output o_busy,
        output o_frame_err
    );

endinterface

// File: rtl/serial_word_deserializer.sv
// Bit-serial to parallel input stage of the FIR filter: grants a frame with a
// one-cycle ready, shifts DATA_WIDTH bits LSB first and holds the word for the core.
module serial_word_deserializer
    import fir_filter_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    localparam int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    serial_word_deserializer_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    deser_state_t          state_r;
    deser_state_t          next_state_s;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [DATA_WIDTH-1:0] word_r;
    logic                  word_valid_r;
    logic                  ready_r;
    logic                  busy_r;
    logic                  frame_err_r;

    logic                  last_bit_s;
    logic                  shift_en_s;
    logic                  abort_s;
    logic                  load_s;
    logic                  ready_d_s;
    logic                  busy_d_s;
    logic [DATA_WIDTH-1:0] assembled_s;

    assign last_bit_s = (cnt_r == LAST_BIT);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.i_din_valid && buffer_can_accept(word_valid_r, bus.i_word_ready)) begin
                    next_state_s = ARM;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ARM: begin
                next_state_s = SHIFT;
            end
            SHIFT: begin
                if (!bus.i_din_valid) begin
                    next_state_s = IDLE;
                end else if (last_bit_s) begin
                    next_state_s = WAIT_LOW;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            WAIT_LOW: begin
                // A held-high valid must drop once before the next grant.
                if (!bus.i_din_valid) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WAIT_LOW;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Per-state control strobes and next values of the registered outputs.
    always_comb begin
        shift_en_s = 1'b0;
        abort_s    = 1'b0;
        load_s     = 1'b0;
        if (state_r == SHIFT) begin
            shift_en_s = bus.i_din_valid;
            abort_s    = !bus.i_din_valid;
            load_s     = bus.i_din_valid && last_bit_s;
        end else begin
            shift_en_s = 1'b0;
            abort_s    = 1'b0;
            load_s     = 1'b0;
        end
        ready_d_s = (next_state_s == ARM);
        busy_d_s  = (next_state_s == ARM) || (next_state_s == SHIFT);
    end

    // The final bit goes straight into the output word, bypassing the shifter.
    always_comb begin
        assembled_s                 = shift_r;
        assembled_s[DATA_WIDTH-1]   = bus.i_din;
    end

    // Bit counter: cleared on entry to SHIFT and on abort, saturates at the last bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= '0;
        end else if ((state_r == ARM) || abort_s) begin
            cnt_r <= '0;
        end else if (shift_en_s && !last_bit_s) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Shift register collecting bits LSB first; partial words are discarded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_r <= '0;
        end else if ((state_r == ARM) || abort_s) begin
            shift_r <= '0;
        end else if (shift_en_s) begin
            shift_r[cnt_r] <= bus.i_din;
        end else begin
            shift_r <= shift_r;
        end
    end

    // Output holding register and valid flag; a same-edge load wins over a consume.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            word_r       <= '0;
            word_valid_r <= 1'b0;
        end else if (load_s) begin
            word_r       <= assembled_s;
            word_valid_r <= 1'b1;
        end else if (bus.i_word_ready) begin
            word_r       <= word_r;
            word_valid_r <= 1'b0;
        end else begin
            word_r       <= word_r;
            word_valid_r <= word_valid_r;
        end
    end

    // Registered status outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            ready_r     <= ready_d_s;
            busy_r      <= busy_d_s;
            frame_err_r <= abort_s;
        end
    end

    assign bus.o_ready      = ready_r;
    assign bus.o_word       = word_r;
    assign bus.o_word_valid = word_valid_r;
    assign bus.o_busy       = busy_r;
    assign bus.o_frame_err  = frame_err_r;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Self-checking bench for serial_word_deserializer: directed scenarios plus
// randomized frames against a transaction-level model of the output buffer.
module tb_serial_word_deserializer;
    import fir_filter_pkg::*;

    localparam int W = DEFAULT_DATA_WIDTH;

    logic tb_clk   = 1'b0;
    logic tb_rst_n = 1'b0;

    always #5 tb_clk = ~tb_clk;

    serial_word_deserializer_if #(.DATA_WIDTH(W)) bus ();

    serial_word_deserializer #(.DATA_WIDTH(W)) dut (
        .i_clk  (tb_clk),
        .i_rst_n(tb_rst_n),
        .bus    (bus)
    );

    int           checks       = 0;
    int           failures     = 0;
    int           cyc          = 0;
    logic         m_valid      = 1'b0;
    logic [W-1:0] m_word       = '0;
    logic [W-1:0] load_word    = '0;
    int           load_due     = -1;
    int           err_due      = -1;
    bit           rand_rdy     = 1'b0;
    int           ready_pulses = 0;
    int           vld_rise_cyc = -1;
    int           rdy_cyc      = -1;
    logic         prev_vld     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: update the buffer model at the edge, compare just after it,
    // then move to the falling edge where stimulus is driven.
    task automatic tick();
        logic consumed;
        logic loading;
        @(posedge tb_clk);
        cyc++;
        if (!tb_rst_n) begin
            m_valid = 1'b0;
            m_word  = '0;
        end else begin
            consumed = m_valid && bus.i_word_ready;
            loading  = (load_due == cyc);
            if (loading) begin
                chk("no_overwrite", 32'(m_valid && !consumed), 32'd0);
                m_valid = 1'b1;
                m_word  = load_word;
            end else if (consumed) begin
                m_valid = 1'b0;
            end
        end
        #1;
        chk("word_valid", 32'(bus.o_word_valid), 32'(m_valid));
        chk("word", 32'(bus.o_word), 32'(m_word));
        chk("frame_err", 32'(bus.o_frame_err), 32'((cyc == err_due) && tb_rst_n));
        if (bus.o_ready) ready_pulses++;
        if (bus.o_word_valid && !prev_vld) vld_rise_cyc = cyc;
        prev_vld = bus.o_word_valid;
        @(negedge tb_clk);
        if (rand_rdy) bus.i_word_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(bus.o_ready), 32'd0);
        chk({tag, "_word"}, 32'(bus.o_word), 32'd0);
        chk({tag, "_word_valid"}, 32'(bus.o_word_valid), 32'd0);
        chk({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
        chk({tag, "_frame_err"}, 32'(bus.o_frame_err), 32'd0);
    endtask

    // Source side of one frame: request, wait for grant, send bits LSB first.
    // abort_at/rst_at select the bit index at which the frame is cut short.
    task automatic send_frame(input logic [W-1:0] w, input int abort_at, input int rst_at,
                              input int hold, input bit armed);
        bit got;
        got             = armed;
        bus.i_din_valid = 1'b1;
        bus.i_din       = 1'b0;
        if (armed) rdy_cyc = cyc;
        for (int n = 0; n < 300 && !got; n++) begin
            tick();
            if (bus.o_ready) begin
                got     = 1'b1;
                rdy_cyc = cyc;
            end
        end
        chk("ready_grant", 32'(got), 32'd1);
        if (!got) begin
            bus.i_din_valid = 1'b0;
            tick();
            return;
        end
        for (int i = 0; i < W; i++) begin
            tick();
            if (i == 0) chk("ready_one_cycle", 32'(bus.o_ready), 32'd0);
            if (i == 3) chk("busy_shift", 32'(bus.o_busy), 32'd1);
            if (i == abort_at) begin
                bus.i_din_valid = 1'b0;
                err_due         = cyc + 1;
                tick();
                chk("busy_after_abort", 32'(bus.o_busy), 32'd0);
                return;
            end
            if (i == rst_at) begin
                #2 tb_rst_n = 1'b0;
                #1;
                check_all_zero("rst_mid");
                bus.i_din_valid = 1'b0;
                tick();
                tick();
                tb_rst_n = 1'b1;
                tick();
                return;
            end
            bus.i_din = w[i];
        end
        load_word = w;
        load_due  = cyc + 1;
        tick();
        chk("busy_done", 32'(bus.o_busy), 32'd0);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("no_rearm_while_held", 32'(bus.o_ready), 32'd0);
        end
        bus.i_din_valid = 1'b0;
        tick();
    endtask

    initial begin
        logic [W-1:0] rw;
        int           ab;
        bus.i_din        = 1'b0;
        bus.i_din_valid  = 1'b0;
        bus.i_word_ready = 1'b0;

        tick();
        tick();
        check_all_zero("reset");
        tb_rst_n = 1'b1;
        tick();

        // Single frame and grant-to-valid latency.
        send_frame(24'h5A3C81, -1, -1, 0, 1'b0);
        chk("t1_word", 32'(bus.o_word), 32'h005A3C81);
        chk("t1_latency", 32'(vld_rise_cyc - rdy_cyc), 32'd25);

        // Extremes back to back with the core always ready.
        bus.i_word_ready = 1'b1;
        ready_pulses     = 0;
        send_frame(24'h7FFFFF, -1, -1, 0, 1'b0);
        chk("t2_word_a", 32'(bus.o_word), 32'h007FFFFF);
        send_frame(24'h800000, -1, -1, 0, 1'b0);
        chk("t2_word_b", 32'(bus.o_word), 32'h00800000);
        chk("t2_ready_pulses", 32'(ready_pulses), 32'd2);

        // Backpressure: a full buffer blocks the next grant until drained.
        bus.i_word_ready = 1'b0;
        send_frame(24'h000001, -1, -1, 0, 1'b0);
        bus.i_din_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t3_ready_blocked", 32'(bus.o_ready), 32'd0);
            chk("t3_word_stable", 32'(bus.o_word), 32'h00000001);
        end
        bus.i_word_ready = 1'b1;
        tick();
        bus.i_word_ready = 1'b0;
        chk("t3_ready_after_drain", 32'(bus.o_ready), 32'd1);
        send_frame(24'hABCDEF, -1, -1, 0, 1'b1);
        chk("t3_word", 32'(bus.o_word), 32'h00ABCDEF);

        // Abort after 10 bits, then a clean frame.
        bus.i_word_ready = 1'b1;
        send_frame(24'hC0FFEE, 10, -1, 0, 1'b0);
        chk("t4_word_kept", 32'(bus.o_word), 32'h00ABCDEF);
        send_frame(24'h123456, -1, -1, 0, 1'b0);
        chk("t4_word", 32'(bus.o_word), 32'h00123456);

        // Asynchronous reset after bit 12, then a clean frame.
        send_frame(24'h555555, -1, 13, 0, 1'b0);
        send_frame(24'hFEDCBA, -1, -1, 0, 1'b0);
        chk("t5_word", 32'(bus.o_word), 32'h00FEDCBA);

        // Valid held high long after the last bit must not re-arm.
        send_frame(24'h0F0F0F, -1, -1, 40, 1'b0);
        send_frame(24'h3C3C3C, -1, -1, 0, 1'b0);
        chk("t6_word", 32'(bus.o_word), 32'h003C3C3C);

        // Randomized frames, aborts, gaps and core backpressure.
        rand_rdy = 1'b1;
        for (int f = 0; f < 20; f++) begin
            rw = W'($urandom);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 2)) : -1;
            send_frame(rw, ab, -1, int'($urandom_range(0, 3)), 1'b0);
        end
        rand_rdy         = 1'b0;
        bus.i_word_ready = 1'b1;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
